// File: rtl/voq_sched_pkg.sv
// Shared types and helpers for the VOQ crossbar scheduler.
package voq_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_PORTS = 16;

  function automatic int next_idx(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/voq_sched_rr_pick.sv
// Combinational rotating-priority finder: first egress at or after start that is
// non-empty and not yet taken.
module rr_pick #(
  parameter int N_PORTS = 4
) (
  input  logic [$clog2(N_PORTS)-1:0] start,
  input  logic [N_PORTS-1:0]         empty,
  input  logic [N_PORTS-1:0]         taken,
  output logic                       found,
  output logic [$clog2(N_PORTS)-1:0] idx
);

  localparam int SEL_W = $clog2(N_PORTS);

  always_comb begin
    logic [SEL_W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    // Walk from the farthest candidate back so the nearest one wins last.
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      cand = start + SEL_W'(k);
      if (!empty[cand] && !taken[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/voq_sched.sv
// N-port VOQ crossbar scheduler: one ingress is matched per SCAN cycle.
// Define VOQ_SCHED_RR_EN for round-robin pointers; otherwise static priority.
module voq_sched
  import voq_sched_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int SEL_W   = $clog2(N_PORTS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sched_en,
  output logic                         sched_ready,
  input  logic [N_PORTS-1:0]           is_busy,
  input  logic [N_PORTS*SEL_W-1:0]     busy_voq_num,
  input  logic [N_PORTS*N_PORTS-1:0]   voq_empty,
  output logic [N_PORTS*SEL_W-1:0]     sched_sel,
  output logic [N_PORTS-1:0]           sched_sel_en,
  output logic                         sched_done
);

  state_t state_reg, state_next;

  logic [SEL_W-1:0]           scan_idx_reg;
  logic [SEL_W-1:0]           scan_cnt_reg;
  logic [N_PORTS-1:0]         busy_snap_reg;
  logic [N_PORTS*SEL_W-1:0]   busy_num_snap_reg;
  logic [N_PORTS*N_PORTS-1:0] empty_snap_reg;
  logic [N_PORTS-1:0]         taken_reg;
  logic [SEL_W-1:0]           stage_sel_reg [N_PORTS];
  logic [N_PORTS-1:0]         stage_en_reg;
  logic [SEL_W-1:0]           sched_sel_reg [N_PORTS];
  logic [N_PORTS-1:0]         sched_sel_en_reg;
  logic                       sched_done_reg;

  logic [N_PORTS-1:0] empty_row    [N_PORTS];
  logic [SEL_W-1:0]   busy_num_row [N_PORTS];
  logic [SEL_W-1:0]   busy_in_row  [N_PORTS];
  logic [N_PORTS-1:0] taken_init;
  logic [SEL_W-1:0]   cur_rr;
  logic [SEL_W-1:0]   start_ingress;
  logic               cur_busy;
  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_rows
    assign empty_row[gi]    = empty_snap_reg[gi*N_PORTS +: N_PORTS];
    assign busy_num_row[gi] = busy_num_snap_reg[gi*SEL_W +: SEL_W];
    assign busy_in_row[gi]  = busy_voq_num[gi*SEL_W +: SEL_W];
    assign sched_sel[gi*SEL_W +: SEL_W] = sched_sel_reg[gi];
  end

  // Egresses held by mid-packet ingresses are unavailable to the picker.
  always_comb begin
    taken_init = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (is_busy[i]) taken_init[busy_in_row[i]] = 1'b1;
    end
  end

  assign cur_busy = busy_snap_reg[scan_idx_reg];

  rr_pick #(.N_PORTS(N_PORTS)) u_pick (
    .start (cur_rr),
    .empty (empty_row[scan_idx_reg]),
    .taken (taken_reg),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef VOQ_SCHED_RR_EN
  logic [SEL_W-1:0] rr_ptr_reg [N_PORTS];
  logic [SEL_W-1:0] start_ingress_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_PORTS; i++) rr_ptr_reg[i] <= '0;
      start_ingress_reg <= '0;
    end else begin
      if (state_reg == SCAN && !cur_busy && pick_found)
        rr_ptr_reg[scan_idx_reg] <= SEL_W'(next_idx(int'(pick_idx), N_PORTS));
      if (state_reg == DONE)
        start_ingress_reg <= SEL_W'(next_idx(int'(start_ingress_reg), N_PORTS));
    end
  end

  assign cur_rr        = rr_ptr_reg[scan_idx_reg];
  assign start_ingress = start_ingress_reg;
`else
  assign cur_rr        = '0;
  assign start_ingress = '0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (sched_en) state_next = SCAN;
      SCAN:    if (scan_cnt_reg == SEL_W'(N_PORTS - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= IDLE;
      scan_idx_reg      <= '0;
      scan_cnt_reg      <= '0;
      busy_snap_reg     <= '0;
      busy_num_snap_reg <= '0;
      empty_snap_reg    <= '0;
      taken_reg         <= '0;
      stage_en_reg      <= '0;
      sched_sel_en_reg  <= '0;
      sched_done_reg    <= 1'b0;
      for (int i = 0; i < N_PORTS; i++) begin
        stage_sel_reg[i] <= '0;
        sched_sel_reg[i] <= '0;
      end
    end else begin
      state_reg      <= state_next;
      sched_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (sched_en) begin
            busy_snap_reg     <= is_busy;
            busy_num_snap_reg <= busy_voq_num;
            empty_snap_reg    <= voq_empty;
            taken_reg         <= taken_init;
            sched_sel_en_reg  <= '0;
            scan_idx_reg      <= start_ingress;
            scan_cnt_reg      <= '0;
          end
        end
        SCAN: begin
          if (cur_busy) begin
            stage_sel_reg[scan_idx_reg] <= busy_num_row[scan_idx_reg];
            stage_en_reg[scan_idx_reg]  <= 1'b1;
          end else if (pick_found) begin
            stage_sel_reg[scan_idx_reg] <= pick_idx;
            stage_en_reg[scan_idx_reg]  <= 1'b1;
            taken_reg[pick_idx]         <= 1'b1;
          end else begin
            stage_sel_reg[scan_idx_reg] <= '0;
            stage_en_reg[scan_idx_reg]  <= 1'b0;
          end
          scan_idx_reg <= SEL_W'(next_idx(int'(scan_idx_reg), N_PORTS));
          scan_cnt_reg <= scan_cnt_reg + 1'b1;
        end
        DONE: begin
          sched_sel_reg    <= stage_sel_reg;
          sched_sel_en_reg <= stage_en_reg;
          sched_done_reg   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sched_ready  = (state_reg == IDLE);
  assign sched_sel_en = sched_sel_en_reg;
  assign sched_done   = sched_done_reg;

endmodule
